// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter: parameter defaults, mode encodings and
// the ceiling-log2 helper used to size select fields.
package bus_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int NSRC_DEF   = 32;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Circular first-one finder: returns the first asserted request at or after
// start, wrapping from N-1 back to 0.
module bus_rr_pick #(
    parameter int N    = 32,
    parameter int SELW = 5
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] win,
    output logic            any
);

    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start) + i;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// Registered multi-source bus arbiter with fixed-priority or round-robin grant,
// contention pulse, sticky contention flag and saturating contention counter.
module bus_arb
    import bus_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NSRC  = NSRC_DEF,
    parameter int MODE  = MODE_FIXED,
    localparam int SELW = clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC-1:0]       src_en,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  hold,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SELW-1:0]       bus_sel,
    output logic                  contention,
    output logic                  err_sticky,
    output logic [7:0]            err_cnt
);

    logic [WIDTH-1:0] bus_out_q,    bus_out_d;
    logic             bus_valid_q,  bus_valid_d;
    logic [SELW-1:0]  bus_sel_q,    bus_sel_d;
    logic             contention_q, contention_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_cnt_q,    err_cnt_d;
    logic [SELW-1:0]  rr_ptr_q,     rr_ptr_d;

    logic [SELW-1:0]  start;
    logic [SELW-1:0]  win;
    logic             any_req;
    logic             multi_req;

    // Fixed priority is the same circular search anchored at index 0.
    assign start     = (MODE == MODE_RR) ? rr_ptr_q : '0;
    assign multi_req = ($countones(src_en) > 1);

    bus_rr_pick #(
        .N    (NSRC),
        .SELW (SELW)
    ) u_pick (
        .req   (src_en),
        .start (start),
        .win   (win),
        .any   (any_req)
    );

    always_comb begin
        bus_out_d    = bus_out_q;
        bus_valid_d  = 1'b0;
        bus_sel_d    = bus_sel_q;
        contention_d = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        rr_ptr_d     = rr_ptr_q;

        // Hold freezes everything, including a pending err_clr.
        if (!hold) begin
            if (any_req) begin
                bus_out_d   = src_data[int'(win)*WIDTH +: WIDTH];
                bus_sel_d   = win;
                bus_valid_d = 1'b1;
                if (MODE == MODE_RR) begin
                    rr_ptr_d = (int'(win) == NSRC - 1) ? '0 : win + SELW'(1);
                end
            end
            if (err_clr) err_sticky_d = 1'b0;
            if (multi_req) begin
                contention_d = 1'b1;
                err_sticky_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_out_q    <= '0;
            bus_valid_q  <= 1'b0;
            bus_sel_q    <= '0;
            contention_q <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            bus_out_q    <= bus_out_d;
            bus_valid_q  <= bus_valid_d;
            bus_sel_q    <= bus_sel_d;
            contention_q <= contention_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus_out    = bus_out_q;
    assign bus_valid  = bus_valid_q;
    assign bus_sel    = bus_sel_q;
    assign contention = contention_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: one fixed-priority and one round-robin instance
// share all inputs; expected values are hand-computed per step.
module tb_bus_arb;

    localparam int WIDTH = 32;
    localparam int NSRC  = 32;
    localparam int SELW  = 5;

    logic                  clk;
    logic                  clr;
    logic [NSRC-1:0]       src_en;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  hold;
    logic                  err_clr;

    logic [WIDTH-1:0] f_out,  r_out;
    logic             f_val,  r_val;
    logic [SELW-1:0]  f_sel,  r_sel;
    logic             f_con,  r_con;
    logic             f_stk,  r_stk;
    logic [7:0]       f_cnt,  r_cnt;

    int pass_cnt;
    int total_cnt;

    bus_arb #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(0)) u_fix (
        .clk(clk), .clr(clr), .src_en(src_en), .src_data(src_data),
        .hold(hold), .err_clr(err_clr),
        .bus_out(f_out), .bus_valid(f_val), .bus_sel(f_sel),
        .contention(f_con), .err_sticky(f_stk), .err_cnt(f_cnt)
    );

    bus_arb #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(1)) u_rr (
        .clk(clk), .clr(clr), .src_en(src_en), .src_data(src_data),
        .hold(hold), .err_clr(err_clr),
        .bus_out(r_out), .bus_valid(r_val), .bus_sel(r_sel),
        .contention(r_con), .err_sticky(r_stk), .err_cnt(r_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_f_out"}, 64'(f_out), 64'h0);
        chk({pfx, "_f_val"}, 64'(f_val), 64'h0);
        chk({pfx, "_f_sel"}, 64'(f_sel), 64'h0);
        chk({pfx, "_f_con"}, 64'(f_con), 64'h0);
        chk({pfx, "_f_stk"}, 64'(f_stk), 64'h0);
        chk({pfx, "_f_cnt"}, 64'(f_cnt), 64'h0);
        chk({pfx, "_r_out"}, 64'(r_out), 64'h0);
        chk({pfx, "_r_val"}, 64'(r_val), 64'h0);
        chk({pfx, "_r_sel"}, 64'(r_sel), 64'h0);
        chk({pfx, "_r_con"}, 64'(r_con), 64'h0);
        chk({pfx, "_r_stk"}, 64'(r_stk), 64'h0);
        chk({pfx, "_r_cnt"}, 64'(r_cnt), 64'h0);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        src_en    = '0;
        hold      = 1'b0;
        err_clr   = 1'b0;
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = 32'h100 + 32'(i);
        src_data[1*WIDTH +: WIDTH] = 32'h0000_AAAA;
        src_data[2*WIDTH +: WIDTH] = 32'h0000_5555;
        src_data[4*WIDTH +: WIDTH] = 32'h0000_1234;

        clr = 1'b1;
        #1 clr = 1'b0;
        #1 chk_all_zero("reset");
        clr = 1'b1;

        // two requesters: lowest wins in fixed mode; rr pointer 0 also picks 1
        src_en = 32'h0000_0006;
        tick();
        chk("fix_out_aaaa", 64'(f_out), 64'h0000_AAAA);
        chk("fix_sel_1",    64'(f_sel), 64'd1);
        chk("fix_con",      64'(f_con), 64'd1);
        chk("fix_cnt_1",    64'(f_cnt), 64'd1);
        chk("fix_val",      64'(f_val), 64'd1);
        chk("rr_sel_1",     64'(r_sel), 64'd1);

        // single grant of 0x1234, then idle keeps data and drops valid
        src_en = 32'h0000_0010;
        tick();
        chk("g1234_out", 64'(f_out), 64'h0000_1234);
        chk("g1234_con", 64'(f_con), 64'd0);
        chk("rr_g4_sel", 64'(r_sel), 64'd4);
        src_en = '0;
        tick();
        chk("idle_out",   64'(f_out), 64'h0000_1234);
        chk("idle_val",   64'(f_val), 64'd0);
        chk("idle_sel",   64'(f_sel), 64'd4);
        chk("idle_r_val", 64'(r_val), 64'd0);

        // rr pointer is 5: search wraps to source 0
        src_en = 32'b1011;
        tick();
        chk("rr_wrap_sel", 64'(r_sel), 64'd0);

        // reset between edges clears everything at once
        #2 clr = 1'b0;
        #1 chk_all_zero("midrst");
        clr = 1'b1;

        // rr rotation restarts at 0: 0,1,3,0
        tick();
        chk("rr_seq0_sel", 64'(r_sel), 64'd0);
        chk("rr_seq0_out", 64'(r_out), 64'h100);
        chk("rr_seq0_cnt", 64'(r_cnt), 64'd1);
        tick();
        chk("rr_seq1_sel", 64'(r_sel), 64'd1);
        chk("rr_seq1_out", 64'(r_out), 64'h0000_AAAA);
        chk("fix_seq1_sel", 64'(f_sel), 64'd0);
        tick();
        chk("rr_seq2_sel", 64'(r_sel), 64'd3);
        chk("rr_seq2_out", 64'(r_out), 64'h103);
        tick();
        chk("rr_seq3_sel", 64'(r_sel), 64'd0);
        chk("rr_seq3_cnt", 64'(r_cnt), 64'd4);
        chk("fix_seq3_cnt", 64'(f_cnt), 64'd4);

        // contention together with err_clr: set wins
        err_clr = 1'b1;
        tick();
        chk("setwins_stk", 64'(f_stk), 64'd1);
        chk("setwins_cnt", 64'(f_cnt), 64'd5);
        chk("rr_seq4_sel", 64'(r_sel), 64'd1);
        src_en = '0;
        tick();
        chk("clr_only_stk",   64'(f_stk), 64'd0);
        chk("clr_only_cnt",   64'(f_cnt), 64'd5);
        chk("clr_only_r_stk", 64'(r_stk), 64'd0);
        err_clr = 1'b0;

        // 300 contention cycles saturate the counter
        src_en = 32'b11;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_f_cnt", 64'(f_cnt), 64'd255);
        chk("sat_r_cnt", 64'(r_cnt), 64'd255);
        chk("sat_f_stk", 64'(f_stk), 64'd1);
        chk("sat_r_sel", 64'(r_sel), 64'd1);

        // hold freezes state and suppresses valid/contention
        hold   = 1'b1;
        src_en = 32'h1;
        tick();
        chk("hold_f_val", 64'(f_val), 64'd0);
        chk("hold_f_con", 64'(f_con), 64'd0);
        chk("hold_f_out", 64'(f_out), 64'h100);
        chk("hold_r_sel", 64'(r_sel), 64'd1);
        chk("hold_r_out", 64'(r_out), 64'h0000_AAAA);
        chk("hold_f_cnt", 64'(f_cnt), 64'd255);
        err_clr = 1'b1;
        src_en  = 32'b11;
        tick();
        chk("hold_over_clr_stk", 64'(f_stk), 64'd1);
        chk("hold_r_con",        64'(r_con), 64'd0);

        // pointer survived hold at 2, so source 0 wins the wrap
        hold    = 1'b0;
        err_clr = 1'b0;
        tick();
        chk("post_hold_r_sel", 64'(r_sel), 64'd0);
        chk("post_hold_r_val", 64'(r_val), 64'd1);
        chk("post_hold_f_con", 64'(f_con), 64'd1);
        chk("post_hold_f_cnt", 64'(f_cnt), 64'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
